// File: rtl/uart_autobaud_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_autobaud_ctrl_if
// Brief    : Line/receiver/status bundle between the autobaud controller and
//            its surroundings (master = line + receiver side, slave = ctrl).
// Revision : 1.0
// ============================================================================
interface uart_autobaud_ctrl_if #(
  parameter int CNT_W  = 16,
  parameter int DVSR_W = 11
);
  logic              serial_in;
  logic              byte_ready;
  logic [7:0]        data_out;
  logic              relearn;
  logic [DVSR_W-1:0] dvsr;
  logic              rx_en;
  logic              locked;
  logic              baud_err;
  logic [CNT_W-1:0]  bit_cycles;

  modport master (
    output serial_in, byte_ready, data_out, relearn,
    input  dvsr, rx_en, locked, baud_err, bit_cycles
  );

  modport slave (
    input  serial_in, byte_ready, data_out, relearn,
    output dvsr, rx_en, locked, baud_err, bit_cycles
  );
endinterface
`default_nettype wire

// File: rtl/uart_autobaud_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_autobaud_ctrl
// Brief    : Measures the sync-byte start bit, derives the 16x divisor,
//            verifies with the receiver and reports lock / failure.
//            Optional verify timeout: UART_AUTOBAUD_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module uart_autobaud_ctrl #(
  parameter int         CNT_W        = 16,
  parameter int         DVSR_W       = 11,
  parameter logic [7:0] SYNC_BYTE    = 8'h55,
  parameter int         MIN_CYCLES   = 32,
  parameter int         IDLE_BITS    = 10,
  parameter int         MAX_RETRY    = 3,
  parameter int         TIMEOUT_BITS = 40
) (
  input  wire logic            clk,
  input  wire logic            rst,
  uart_autobaud_ctrl_if.slave  bus
);

  localparam logic [2:0] c_HUNT      = 3'd0;
  localparam logic [2:0] c_MEASURE   = 3'd1;
  localparam logic [2:0] c_IDLE_WAIT = 3'd2;
  localparam logic [2:0] c_VERIFY    = 3'd3;
  localparam logic [2:0] c_FAIL_CHK  = 3'd4;
  localparam logic [2:0] c_LOCKED    = 3'd5;
  localparam logic [2:0] c_FAIL      = 3'd6;

  localparam int c_BIT_MAX = (IDLE_BITS > TIMEOUT_BITS) ? IDLE_BITS : TIMEOUT_BITS;
  localparam int c_BIT_W   = $clog2(c_BIT_MAX + 1);
  localparam int c_RTY_W   = $clog2(MAX_RETRY + 1);

  logic               r_sync1, r_sync2, r_hist;
  logic [2:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_sub;
  logic [c_BIT_W-1:0] r_bits;
  logic [c_RTY_W-1:0] r_retry;
  logic [DVSR_W-1:0]  r_dvsr;
  logic               r_rx_en, r_locked, r_baud_err;
  logic [CNT_W-1:0]   r_bit_cycles;

  logic               w_fall, w_rise, w_cnt_sat, w_meas_bad, w_period_end;
  logic [CNT_W:0]     w_dvsr_full;
  logic [DVSR_W-1:0]  w_dvsr;
  logic [c_RTY_W-1:0] w_retry_nxt;

  // Sync flops idle high so reset release never fakes a falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_hist  <= 1'b1;
    end else begin
      r_sync1 <= bus.serial_in;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign w_fall       = r_hist & ~r_sync2;
  assign w_rise       = ~r_hist & r_sync2;
  assign w_cnt_sat    = &r_cnt;
  assign w_dvsr_full  = ({1'b0, r_cnt} + (CNT_W+1)'(8)) >> 4;
  assign w_dvsr       = DVSR_W'(w_dvsr_full);
  assign w_meas_bad   = (r_cnt < CNT_W'(MIN_CYCLES)) | w_cnt_sat | (w_dvsr == '0);
  assign w_period_end = (r_sub == r_bit_cycles - CNT_W'(1));
  assign w_retry_nxt  = r_retry + c_RTY_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= c_HUNT;
      r_cnt        <= '0;
      r_sub        <= '0;
      r_bits       <= '0;
      r_retry      <= '0;
      r_dvsr       <= '0;
      r_rx_en      <= 1'b0;
      r_locked     <= 1'b0;
      r_baud_err   <= 1'b0;
      r_bit_cycles <= '0;
    end else if (bus.relearn) begin
      r_state    <= c_HUNT;
      r_cnt      <= '0;
      r_sub      <= '0;
      r_bits     <= '0;
      r_retry    <= '0;
      r_rx_en    <= 1'b0;
      r_locked   <= 1'b0;
      r_baud_err <= 1'b0;
    end else begin
      case (r_state)
        c_HUNT: begin
          if (w_fall) begin
            r_cnt   <= CNT_W'(1);
            r_state <= c_MEASURE;
          end
        end
        c_MEASURE: begin
          if (w_rise) begin
            if (w_meas_bad) begin
              r_state <= c_FAIL_CHK;
            end else begin
              r_bit_cycles <= r_cnt;
              r_dvsr       <= w_dvsr;
              r_sub        <= '0;
              r_bits       <= '0;
              r_state      <= c_IDLE_WAIT;
            end
          end else if (!w_cnt_sat) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        c_IDLE_WAIT: begin
          if (!r_sync2) begin
            r_sub  <= '0;
            r_bits <= '0;
          end else if (w_period_end) begin
            r_sub <= '0;
            if (r_bits == c_BIT_W'(IDLE_BITS - 1)) begin
              r_bits  <= '0;
              r_rx_en <= 1'b1;
              r_state <= c_VERIFY;
            end else begin
              r_bits <= r_bits + c_BIT_W'(1);
            end
          end else begin
            r_sub <= r_sub + CNT_W'(1);
          end
        end
        c_VERIFY: begin
          if (bus.byte_ready) begin
            if (bus.data_out == SYNC_BYTE) begin
              r_locked <= 1'b1;
              r_retry  <= '0;
              r_state  <= c_LOCKED;
            end else begin
              r_rx_en <= 1'b0;
              r_state <= c_FAIL_CHK;
            end
          end
`ifdef UART_AUTOBAUD_TIMEOUT_EN
          else if (w_period_end) begin
            r_sub <= '0;
            if (r_bits == c_BIT_W'(TIMEOUT_BITS - 1)) begin
              r_bits  <= '0;
              r_rx_en <= 1'b0;
              r_state <= c_FAIL_CHK;
            end else begin
              r_bits <= r_bits + c_BIT_W'(1);
            end
          end else begin
            r_sub <= r_sub + CNT_W'(1);
          end
`endif
        end
        c_FAIL_CHK: begin
          r_retry <= w_retry_nxt;
          if (w_retry_nxt == c_RTY_W'(MAX_RETRY)) begin
            r_baud_err <= 1'b1;
            r_state    <= c_FAIL;
          end else begin
            r_state <= c_HUNT;
          end
        end
        c_LOCKED: r_state <= c_LOCKED;
        c_FAIL:   r_state <= c_FAIL;
        default:  r_state <= c_HUNT;
      endcase
    end
  end

  assign bus.dvsr       = r_dvsr;
  assign bus.rx_en      = r_rx_en;
  assign bus.locked     = r_locked;
  assign bus.baud_err   = r_baud_err;
  assign bus.bit_cycles = r_bit_cycles;

endmodule
`default_nettype wire

// File: tb/tb_uart_autobaud_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_autobaud_ctrl
// Brief    : Directed stimulus with an output-event scoreboard for
//            uart_autobaud_ctrl (50 MHz clock).
// Revision : 1.0
// ============================================================================
module tb_uart_autobaud_ctrl;
  localparam int CNT_W  = 16;
  localparam int DVSR_W = 11;

  typedef struct packed {
    logic              rx_en;
    logic              locked;
    logic              baud_err;
    logic [DVSR_W-1:0] dvsr;
    logic [CNT_W-1:0]  bc;
  } obs_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  probe_req = 1'b0;
  logic  done = 1'b0;
  obs_t  exp_q[$];
  string name_q[$];
  obs_t  cur;
  obs_t  last = '0;
  obs_t  e;
  string n;
  int    bc_diff;
  int    checks = 0;
  int    errors = 0;

  always #10 clk = ~clk;

  uart_autobaud_ctrl_if #(.CNT_W(CNT_W), .DVSR_W(DVSR_W)) bus();

  uart_autobaud_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick(input int cnt);
    repeat (cnt) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_ev(input string nm, input logic rx, input logic lk, input logic be,
                           input logic [DVSR_W-1:0] dv, input logic [CNT_W-1:0] bc);
    exp_q.push_back({rx, lk, be, dv, bc});
    name_q.push_back(nm);
  endtask

  // Forces a comparison at the next falling clock edge even without an output change.
  task automatic probe(input string nm, input logic rx, input logic lk, input logic be,
                       input logic [DVSR_W-1:0] dv, input logic [CNT_W-1:0] bc);
    expect_ev(nm, rx, lk, be, dv, bc);
    probe_req = 1'b1;
    tick(1);
    probe_req = 1'b0;
  endtask

  task automatic line_low(input int cyc);
    bus.serial_in = 1'b0;
    tick(cyc);
    bus.serial_in = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int per);
    bus.serial_in = 1'b0;
    tick(per);
    for (int i = 0; i < 8; i++) begin
      bus.serial_in = b[i];
      tick(per);
    end
    bus.serial_in = 1'b1;
    tick(per);
  endtask

  task automatic train_start(input int per);
    line_low(per);
    tick(12 * per);
  endtask

  task automatic glitch();
    line_low(10);
    tick(20);
  endtask

  task automatic pulse_relearn();
    bus.relearn = 1'b1;
    tick(1);
    bus.relearn = 1'b0;
    tick(3);
  endtask

  task automatic send_byte(input logic [7:0] d);
    bus.byte_ready = 1'b1;
    bus.data_out   = d;
    tick(1);
    bus.byte_ready = 1'b0;
    bus.data_out   = 8'h00;
    tick(3);
  endtask

  initial begin
    bus.serial_in  = 1'b1;
    bus.byte_ready = 1'b0;
    bus.data_out   = 8'h00;
    bus.relearn    = 1'b0;
    #1 rst = 1'b0;
    tick(4);
    probe("reset_state", 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick(5);

    // 115200 baud full sync frame, then verification byte
    expect_ev("meas_115200", 0, 0, 0, 27, 434);
    expect_ev("rx_en_on", 1, 0, 0, 27, 434);
    send_frame(8'h55, 434);
    tick(12 * 434);
    expect_ev("lock_115200", 1, 1, 0, 27, 434);
    send_byte(8'h55);
    send_byte(8'h12);
    probe("locked_holds", 1, 1, 0, 27, 434);

    expect_ev("relearn_while_locked", 0, 0, 0, 27, 434);
    pulse_relearn();

    // async reset in the middle of a measurement
    bus.serial_in = 1'b0;
    tick(100);
    expect_ev("reset_mid_measure", 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick(3);
    bus.serial_in = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(50);
    probe("post_reset_quiet", 0, 0, 0, 0, 0);

    // 9600 baud measurement; relearn keeps the divisor
    expect_ev("meas_9600", 0, 0, 0, 326, 5208);
    line_low(5208);
    tick(20);
    pulse_relearn();
    probe("relearn_keeps_dvsr", 0, 0, 0, 326, 5208);

    // wrong verification byte is the first failed attempt
    expect_ev("meas_115200_b", 0, 0, 0, 27, 434);
    expect_ev("rx_en_on_b", 1, 0, 0, 27, 434);
    train_start(434);
    expect_ev("mismatch_5a", 0, 0, 0, 27, 434);
    send_byte(8'h5A);

    glitch();
    probe("glitch_retry2", 0, 0, 0, 27, 434);
    expect_ev("baud_err_retry3", 0, 0, 1, 27, 434);
    glitch();
    glitch();

    expect_ev("relearn_clears_err", 0, 0, 0, 27, 434);
    pulse_relearn();
    glitch();
    glitch();
    probe("two_glitches", 0, 0, 0, 27, 434);
    expect_ev("three_glitches", 0, 0, 1, 27, 434);
    glitch();
    expect_ev("relearn_clears_err_b", 0, 0, 0, 27, 434);
    pulse_relearn();

    // no verification byte arrives
    expect_ev("rx_en_on_c", 1, 0, 0, 27, 434);
    train_start(434);
`ifdef UART_AUTOBAUD_TIMEOUT_EN
    expect_ev("verify_timeout", 0, 0, 0, 27, 434);
    tick(45 * 434);
    probe("after_timeout", 0, 0, 0, 27, 434);
    pulse_relearn();
`else
    tick(45 * 434);
    probe("verify_waits", 1, 0, 0, 27, 434);
    expect_ev("relearn_in_verify", 0, 0, 0, 27, 434);
    pulse_relearn();
`endif

    // relearn beats a correct byte in the same cycle
    expect_ev("rx_en_on_d", 1, 0, 0, 27, 434);
    train_start(434);
    expect_ev("relearn_beats_byte", 0, 0, 0, 27, 434);
    bus.relearn    = 1'b1;
    bus.byte_ready = 1'b1;
    bus.data_out   = 8'h55;
    tick(1);
    bus.relearn    = 1'b0;
    bus.byte_ready = 1'b0;
    bus.data_out   = 8'h00;
    tick(3);
    probe("no_lock_after_relearn", 0, 0, 0, 27, 434);

    expect_ev("rx_en_on_e", 1, 0, 0, 27, 434);
    train_start(434);
    expect_ev("lock_final", 1, 1, 0, 27, 434);
    send_byte(8'h55);

    done = 1'b1;
  end

  always @(negedge clk) begin
    cur = {bus.rx_en, bus.locked, bus.baud_err, bus.dvsr, bus.bit_cycles};
    if (cur !== last || probe_req) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: got rx_en=%0b locked=%0b baud_err=%0b dvsr=%0d bit_cycles=%0d, required no change",
                 cur.rx_en, cur.locked, cur.baud_err, cur.dvsr, cur.bc);
      end else begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        bc_diff = int'(cur.bc) - int'(e.bc);
        if (cur.rx_en !== e.rx_en || cur.locked !== e.locked || cur.baud_err !== e.baud_err ||
            cur.dvsr !== e.dvsr || bc_diff > 1 || bc_diff < -1 || $isunknown(cur.bc)) begin
          errors++;
          $display("FAIL %s: got rx_en=%0b locked=%0b baud_err=%0b dvsr=%0d bit_cycles=%0d, required rx_en=%0b locked=%0b baud_err=%0b dvsr=%0d bit_cycles=%0d",
                   n, cur.rx_en, cur.locked, cur.baud_err, cur.dvsr, cur.bc,
                   e.rx_en, e.locked, e.baud_err, e.dvsr, e.bc);
        end
      end
      last = cur;
    end
    if (done) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL missing_events: got %0d pending, required 0 (next %s)", exp_q.size(), name_q[0]);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got no completion, required completion within 10 ms");
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire

// File: doc/uart_autobaud_ctrl.md
Name: uart_autobaud_ctrl

Overview:
- Configuration controller for the UART receive path; sits beside the receiver, which takes clk, rst, serial_in and dvsr and produces data_out and byte_ready.
- Measures the start-bit width of a host-sent sync byte on serial_in and computes the 16x oversampling divisor dvsr.
- Enables the receiver, checks that the next received byte equals the sync byte, then declares lock.
- Retries on mismatch or bad measurement; reports failure after MAX_RETRY failed attempts.

Parameters:
CNT_W, 16, width of the bit-period measurement counter (saturating).
DVSR_W, 11, width of the dvsr output.
SYNC_BYTE, 8'h55, byte the host sends for training and verification.
MIN_CYCLES, 32, shortest legal bit period in clk cycles; shorter low pulses are rejected as glitches.
IDLE_BITS, 10, number of consecutive high bit periods that end a training frame.
MAX_RETRY, 3, failed attempts allowed before baud_err.
TIMEOUT_BITS, 40, verify-phase timeout in bit periods (used only with the optional feature).

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
serial_in  input  1  raw RX line, idle high; synchronised internally with 2 flops
byte_ready  input  1  one-cycle strobe from the receiver
data_out  input  8  received byte, valid while byte_ready=1
relearn  input  1  one-cycle request to restart training from any state
dvsr  output  DVSR_W  divisor driven to the receiver
rx_en  output  1  receiver enable (receiver input gated by rx_en)
locked  output  1  baud rate trained and verified
baud_err  output  1  training failed; sticky until relearn or reset
bit_cycles  output  CNT_W  last measured bit period in clk cycles

Behaviour:
- Reset (rst=0, async): state HUNT; dvsr=0, rx_en=0, locked=0, baud_err=0, bit_cycles=0, retry count=0, all counters 0.
- Edge detection uses the synchronised line (2-flop sync plus 1 history flop); the fixed 2-cycle latency cancels out of the width measurement.
- HUNT: wait for a synced falling edge -> MEASURE.
  - cnt is loaded with 1 on the fall cycle, then increments each cycle the line stays low, saturating at all-ones.
- MEASURE, on a synced rising edge:
  - If cnt < MIN_CYCLES or cnt is saturated: attempt fails -> FAIL_CHK.
  - Otherwise: bit_cycles<=cnt; dvsr<=(cnt+8)>>4, truncated to DVSR_W, rounded to nearest -> IDLE_WAIT.
  - A dvsr result of 0 also counts as a failure.
- IDLE_WAIT:
  - A sub-counter counts bit_cycles per bit period and a bit counter counts periods while the line is high.
  - Any low sample clears both counters.
  - When the bit count reaches IDLE_BITS -> VERIFY, and rx_en<=1 on that transition.
- VERIFY: wait for byte_ready.
  - data_out==SYNC_BYTE -> LOCKED; locked<=1; retry count cleared.
  - Any other byte -> FAIL_CHK; rx_en<=0.
- FAIL_CHK (single cycle): retry count +1.
  - If the new count == MAX_RETRY -> FAIL with baud_err<=1.
  - Otherwise -> HUNT.
  - dvsr keeps its last value.
- LOCKED: holds; byte_ready is ignored; rx_en=1 and locked=1 are steady.
- FAIL: holds; rx_en=0.
- relearn, when asserted in any state, wins over every other transition in that cycle:
  - next state is HUNT;
  - locked, rx_en, baud_err, retry count and all counters are cleared;
  - dvsr and bit_cycles keep their values.
- byte_ready in any state other than VERIFY is ignored.
- A rising edge and a saturated counter in the same cycle count as a failure.

Optional Feature:
- UART_AUTOBAUD_TIMEOUT_EN defined:
  - VERIFY also counts bit periods from entry.
  - If TIMEOUT_BITS periods elapse with no byte_ready -> FAIL_CHK with rx_en<=0.
  - If byte_ready and the timeout occur in the same cycle, byte_ready takes priority.
- UART_AUTOBAUD_TIMEOUT_EN undefined: VERIFY waits indefinitely and the timeout counter is not built.

Test Plan:
- Reset checks, 50 MHz clk:
  - Hold rst=0 mid-MEASURE -> all outputs 0, state HUNT.
  - Release rst -> no activity until the next falling edge.
- 115200 baud (434 cycles/bit), host sends 0x55, idles, then sends 0x55 again:
  - After the first start bit: bit_cycles=434±1, dvsr=27.
  - After the second byte's byte_ready with data_out=0x55: locked=1, rx_en=1.
- 9600 baud (5208 cycles/bit):
  - First 0x55 gives dvsr=326.
  - Second byte delivered as 0x5A: retry=1, back to HUNT.
  - Next pair correct -> locked=1.
- 10-cycle low glitch on serial_in: counts as a failed attempt.
  - Three glitches give baud_err=1 and rx_en=0.
  - relearn pulse -> baud_err=0, state HUNT, dvsr unchanged.
- Timeout, UART_AUTOBAUD_TIMEOUT_EN defined: train at 115200, then no second byte.
  - After 40×434 cycles in VERIFY: rx_en=0, retry=1.
  - With the macro undefined, the design stays in VERIFY after 100 bit periods.
- Same-cycle events:
  - relearn in the same cycle as the VERIFY byte_ready=0x55 -> HUNT, locked stays 0.
  - relearn while LOCKED -> locked=0 the next cycle.
